alu_retire: RTL and testbench
=============================

// Module: alu_retire
// PURPOSE
// - Consumer end of the ALU result interface in the 8-bit nRisc pipeline.
// - Tracks each op issued to the registered ALU and retires it one cycle later.
// - Retiring an op means one of: writing solution to the register file, or redirecting the PC (BNZ) and flushing younger ops.
// - Sits between EX and the register-file write port / fetch PC mux.
// PARAMETERS
// DATA_W        8   datapath width; matches ALU solution/jump_data
// REG_ADDR_W    2   register-file address width
// FLUSH_CYCLES  2   cycles flush stays high after a taken redirect (>=1)
// CNT_W         16  width of retire_count
// PORTS
// clock          in   1           rising-edge clock
// reset          in   1           synchronous, active-high
// issue_valid    in   1           op presented to ALU this cycle
// issue_op       in   3           opcode (same encoding as ALU operation)
// issue_rd       in   REG_ADDR_W  destination register of issued op
// alu_solution   in   DATA_W      ALU solution, valid the cycle after issue
// alu_jump_data  in   DATA_W      ALU jump_data, valid the cycle after issue
// rf_we          out  1           register-file write enable (1-cycle pulse)
// rf_waddr       out  REG_ADDR_W  write address
// rf_wdata       out  DATA_W      write data
// pc_redirect    out  1           1-cycle pulse: fetch must load pc_target
// pc_target      out  DATA_W      redirect target
// flush          out  1           high while younger ops are being squashed
// retire_count   out  CNT_W       count of retired (non-squashed) ops
// BEHAVIOUR
// - Reset: all outputs 0, slot empty, FSM=RUN, count=0; in-flight ops dropped.
// - Post-reset: no rf_we/pc_redirect until a new issue_valid is seen.
// - Slot register: captures {issue_valid,issue_op,issue_rd} each edge unless squashed.
// - Latency: issue in cycle t -> ALU output in t+1 -> retire edge at end of t+1.
//   rf_we/pc_redirect are then visible during t+2.
// - Retire of a valid slot, by opcode:
//   000 ADD, 001 SUB, 010 MUL, 110 BEQ:
//     rf_we=1, rf_waddr=slot rd, rf_wdata=alu_solution.
//     BEQ writes its 0/1 compare flag.
//   111 BNZ: no write; pc_redirect=1; pc_target=alu_jump_data; FSM -> FLUSH.
//   011,100,101: no write, no redirect; still counted as retired.
// - rf_we, pc_redirect: single-cycle pulses. rf_waddr/rf_wdata/pc_target hold their last value.
// - FSM RUN:
//   BNZ retire -> FLUSH, flush_cnt=FLUSH_CYCLES.
//   On that same edge the op being issued is captured as invalid (squashed).
// - FSM FLUSH:
//   flush=1; issue_valid ignored (slot loads invalid).
//   flush_cnt decrements each edge; ->RUN when it reaches 1 (FLUSH_CYCLES high cycles).
// - Squashed ops: never write, redirect, or count.
//   A BNZ cannot retire in FLUSH.
// - retire_count: +1 per retired valid slot; wraps 2^CNT_W-1 -> 0.
// - Reset mid-operation (e.g. in FLUSH or with a valid slot):
//   next cycle all outputs 0, FSM=RUN, no pending retire.
// - Only valid slots are observed; ALU's idle solution=0 / jump_data=1xxxxxxx is never decoded.
// TESTING
// - ADD rd=2 issued c0, alu_solution=0x0C in c1 -> c2: rf_we=1,waddr=2,wdata=0x0C; c3: rf_we=0; count=1.
// - Back-to-back SUB rd=1 (0x05), MUL rd=3 (0x40), BEQ rd=0 (0x01) c0..c2
//   -> writes in c2,c3,c4 in order with those values; count=3.
// - BNZ c0, jump_data=0x14 in c1, ADD issued c1,c2
//   -> c2: pc_redirect=1,pc_target=0x14,flush=1; c3 flush=1; c4 flush=0.
//   Neither ADD writes; count=1.
// - Opcode 100 rd=3 issued with alu_solution=0xFF -> no rf_we, no redirect, count increments.
// - ADD issued c0, reset=1 in c1 -> c2: rf_we=0, count=0, flush=0.
// - Preload retire_count=0xFFFF via 65535 retires, one more ADD -> retire_count=0x0000, write still occurs.

Source files
------------

// File: rtl/alu_retire.sv
// ============================================================================
// Module      : alu_retire
// Description : Retires ops issued to the registered ALU one cycle after
//               issue: register-file write or BNZ redirect with flush.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_retire #(
    parameter int DATA_W       = 8,
    parameter int REG_ADDR_W   = 2,
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  issue_valid,
    input  logic [2:0]            issue_op,
    input  logic [REG_ADDR_W-1:0] issue_rd,
    input  logic [DATA_W-1:0]     alu_solution,
    input  logic [DATA_W-1:0]     alu_jump_data,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic                  pc_redirect,
    output logic [DATA_W-1:0]     pc_target,
    output logic                  flush,
    output logic [CNT_W-1:0]      retire_count
);

    localparam logic [2:0] c_OP_ADD = 3'b000;
    localparam logic [2:0] c_OP_SUB = 3'b001;
    localparam logic [2:0] c_OP_MUL = 3'b010;
    localparam logic [2:0] c_OP_BEQ = 3'b110;
    localparam logic [2:0] c_OP_BNZ = 3'b111;

    localparam logic [0:0] c_ST_RUN   = 1'b0;
    localparam logic [0:0] c_ST_FLUSH = 1'b1;

    localparam int               c_FCW        = (FLUSH_CYCLES < 2) ? 1 : $clog2(FLUSH_CYCLES + 1);
    localparam logic [c_FCW-1:0] c_FLUSH_INIT = c_FCW'(FLUSH_CYCLES);
    localparam logic [c_FCW-1:0] c_FLUSH_ONE  = c_FCW'(1);

    logic [0:0]            r_state;
    logic [c_FCW-1:0]      r_flush_cnt;
    logic                  r_slot_valid;
    logic [2:0]            r_slot_op;
    logic [REG_ADDR_W-1:0] r_slot_rd;

    logic                  r_rf_we;
    logic [REG_ADDR_W-1:0] r_rf_waddr;
    logic [DATA_W-1:0]     r_rf_wdata;
    logic                  r_pc_redirect;
    logic [DATA_W-1:0]     r_pc_target;
    logic                  r_flush;
    logic [CNT_W-1:0]      r_retire_count;

    logic w_is_write;
    logic w_is_bnz;
    logic w_take_redirect;

    always_comb begin
        w_is_write = 1'b0;
        w_is_bnz   = 1'b0;
        case (r_slot_op)
            c_OP_ADD, c_OP_SUB, c_OP_MUL, c_OP_BEQ: w_is_write = 1'b1;
            c_OP_BNZ:                               w_is_bnz   = 1'b1;
            default: ;
        endcase
        // Slots captured during FLUSH are always invalid, so this only fires in RUN.
        w_take_redirect = r_slot_valid && w_is_bnz;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state        <= c_ST_RUN;
            r_flush_cnt    <= '0;
            r_slot_valid   <= 1'b0;
            r_slot_op      <= '0;
            r_slot_rd      <= '0;
            r_rf_we        <= 1'b0;
            r_rf_waddr     <= '0;
            r_rf_wdata     <= '0;
            r_pc_redirect  <= 1'b0;
            r_pc_target    <= '0;
            r_flush        <= 1'b0;
            r_retire_count <= '0;
        end else begin
            r_rf_we       <= 1'b0;
            r_pc_redirect <= 1'b0;

            if (r_slot_valid) begin
                r_retire_count <= r_retire_count + 1'b1;
                if (w_is_write) begin
                    r_rf_we    <= 1'b1;
                    r_rf_waddr <= r_slot_rd;
                    r_rf_wdata <= alu_solution;
                end
                if (w_is_bnz) begin
                    r_pc_redirect <= 1'b1;
                    r_pc_target   <= alu_jump_data;
                end
            end

            // The op presented on a redirect edge or during FLUSH is squashed.
            r_slot_op <= issue_op;
            r_slot_rd <= issue_rd;
            if (r_state == c_ST_FLUSH || w_take_redirect) begin
                r_slot_valid <= 1'b0;
            end else begin
                r_slot_valid <= issue_valid;
            end

            case (r_state)
                c_ST_RUN: begin
                    if (w_take_redirect) begin
                        r_state     <= c_ST_FLUSH;
                        r_flush_cnt <= c_FLUSH_INIT;
                        r_flush     <= 1'b1;
                    end
                end
                default: begin
                    if (r_flush_cnt <= c_FLUSH_ONE) begin
                        r_state     <= c_ST_RUN;
                        r_flush_cnt <= '0;
                        r_flush     <= 1'b0;
                    end else begin
                        r_flush_cnt <= r_flush_cnt - 1'b1;
                    end
                end
            endcase
        end
    end

    assign rf_we        = r_rf_we;
    assign rf_waddr     = r_rf_waddr;
    assign rf_wdata     = r_rf_wdata;
    assign pc_redirect  = r_pc_redirect;
    assign pc_target    = r_pc_target;
    assign flush        = r_flush;
    assign retire_count = r_retire_count;

endmodule

`default_nettype wire

// File: tb/tb_alu_retire.sv
// ============================================================================
// Module      : tb_alu_retire
// Description : Directed self-checking bench for alu_retire.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_retire;

    logic        clock = 1'b0;
    logic        reset;
    logic        issue_valid;
    logic [2:0]  issue_op;
    logic [1:0]  issue_rd;
    logic [7:0]  alu_solution;
    logic [7:0]  alu_jump_data;
    logic        rf_we;
    logic [1:0]  rf_waddr;
    logic [7:0]  rf_wdata;
    logic        pc_redirect;
    logic [7:0]  pc_target;
    logic        flush;
    logic [15:0] retire_count;

    int n_checks = 0;
    int n_errors = 0;

    alu_retire #(
        .DATA_W      (8),
        .REG_ADDR_W  (2),
        .FLUSH_CYCLES(2),
        .CNT_W       (16)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .issue_valid  (issue_valid),
        .issue_op     (issue_op),
        .issue_rd     (issue_rd),
        .alu_solution (alu_solution),
        .alu_jump_data(alu_jump_data),
        .rf_we        (rf_we),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .pc_redirect  (pc_redirect),
        .pc_target    (pc_target),
        .flush        (flush),
        .retire_count (retire_count)
    );

    always #5 clock = ~clock;

    // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] rd);
        issue_valid = 1'b1;
        issue_op    = op;
        issue_rd    = rd;
    endtask

    task automatic idle();
        issue_valid = 1'b0;
        issue_op    = 3'b000;
        issue_rd    = 2'd0;
    endtask

    initial begin
        reset         = 1'b1;
        alu_solution  = 8'h00;
        alu_jump_data = 8'h80;
        idle();
        step();
        step();
        check("rst_rf_we", rf_we, 1'b0);
        check("rst_waddr", rf_waddr, 2'd0);
        check("rst_wdata", rf_wdata, 8'h00);
        check("rst_redirect", pc_redirect, 1'b0);
        check("rst_target", pc_target, 8'h00);
        check("rst_flush", flush, 1'b0);
        check("rst_count", retire_count, 16'h0000);
        reset = 1'b0;
        step();
        check("idle_no_we", rf_we, 1'b0);

        // Single ADD rd=2
        issue(3'b000, 2'd2);
        step();
        idle();
        alu_solution = 8'h0C;
        step();
        check("add_we", rf_we, 1'b1);
        check("add_waddr", rf_waddr, 2'd2);
        check("add_wdata", rf_wdata, 8'h0C);
        check("add_count", retire_count, 16'd1);
        check("add_no_redirect", pc_redirect, 1'b0);
        step();
        check("add_we_pulse", rf_we, 1'b0);
        check("add_wdata_hold", rf_wdata, 8'h0C);

        // Back-to-back SUB/MUL/BEQ
        issue(3'b001, 2'd1);
        step();
        alu_solution = 8'h05;
        issue(3'b010, 2'd3);
        step();
        check("sub_we", rf_we, 1'b1);
        check("sub_waddr", rf_waddr, 2'd1);
        check("sub_wdata", rf_wdata, 8'h05);
        alu_solution = 8'h40;
        issue(3'b110, 2'd0);
        step();
        check("mul_we", rf_we, 1'b1);
        check("mul_waddr", rf_waddr, 2'd3);
        check("mul_wdata", rf_wdata, 8'h40);
        alu_solution = 8'h01;
        idle();
        step();
        check("beq_we", rf_we, 1'b1);
        check("beq_waddr", rf_waddr, 2'd0);
        check("beq_wdata", rf_wdata, 8'h01);
        check("b2b_count", retire_count, 16'd4);
        alu_solution = 8'h00;
        step();
        check("b2b_we_end", rf_we, 1'b0);

        // BNZ redirect with two younger ADDs squashed
        issue(3'b111, 2'd0);
        step();
        alu_jump_data = 8'h14;
        alu_solution  = 8'h99;
        issue(3'b000, 2'd1);
        step();
        check("bnz_redirect", pc_redirect, 1'b1);
        check("bnz_target", pc_target, 8'h14);
        check("bnz_flush_c2", flush, 1'b1);
        check("bnz_no_we", rf_we, 1'b0);
        alu_jump_data = 8'h80;
        alu_solution  = 8'h77;
        issue(3'b000, 2'd2);
        step();
        idle();
        check("bnz_flush_c3", flush, 1'b1);
        check("bnz_redirect_pulse", pc_redirect, 1'b0);
        check("sq1_no_we", rf_we, 1'b0);
        check("bnz_target_hold", pc_target, 8'h14);
        step();
        check("bnz_flush_c4", flush, 1'b0);
        check("sq2_no_we", rf_we, 1'b0);
        step();
        check("bnz_tail_no_we", rf_we, 1'b0);
        check("bnz_count", retire_count, 16'd5);

        // Opcodes 100 and 101 retire without side effects
        issue(3'b100, 2'd3);
        step();
        alu_solution = 8'hFF;
        issue(3'b101, 2'd1);
        step();
        check("op100_no_we", rf_we, 1'b0);
        check("op100_no_redirect", pc_redirect, 1'b0);
        check("op100_count", retire_count, 16'd6);
        idle();
        step();
        check("op101_no_we", rf_we, 1'b0);
        check("op101_count", retire_count, 16'd7);
        check("wdata_hold", rf_wdata, 8'h01);

        // Reset with an op in flight
        alu_solution = 8'h00;
        issue(3'b000, 2'd1);
        step();
        idle();
        reset        = 1'b1;
        alu_solution = 8'h33;
        step();
        reset = 1'b0;
        check("rst_mid_we", rf_we, 1'b0);
        check("rst_mid_count", retire_count, 16'd0);
        check("rst_mid_flush", flush, 1'b0);
        check("rst_mid_wdata", rf_wdata, 8'h00);
        step();
        check("rst_mid_no_late_we", rf_we, 1'b0);

        // Reset during FLUSH
        issue(3'b111, 2'd0);
        step();
        idle();
        alu_jump_data = 8'h20;
        step();
        check("rst_fl_pre_flush", flush, 1'b1);
        check("rst_fl_pre_target", pc_target, 8'h20);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("rst_fl_flush", flush, 1'b0);
        check("rst_fl_target", pc_target, 8'h00);
        check("rst_fl_count", retire_count, 16'd0);
        alu_jump_data = 8'h80;
        // Issuing right after reset must not be squashed
        issue(3'b000, 2'd3);
        step();
        idle();
        alu_solution = 8'hA5;
        step();
        check("post_rst_we", rf_we, 1'b1);
        check("post_rst_wdata", rf_wdata, 8'hA5);
        check("post_rst_count", retire_count, 16'd1);

        // Counter wrap: reach 0xFFFF then one more ADD
        reset = 1'b1;
        step();
        reset = 1'b0;
        issue(3'b011, 2'd0);
        repeat (65535) step();
        issue(3'b000, 2'd2);
        step();
        idle();
        alu_solution = 8'h5A;
        check("wrap_pre_count", retire_count, 16'hFFFF);
        check("wrap_pre_no_we", rf_we, 1'b0);
        step();
        check("wrap_count", retire_count, 16'h0000);
        check("wrap_we", rf_we, 1'b1);
        check("wrap_waddr", rf_waddr, 2'd2);
        check("wrap_wdata", rf_wdata, 8'h5A);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
